// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int AW    = 5;
  localparam int IW    = 16;
  localparam int DEPTH = 1 << AW;
  localparam logic [IW-1:0] HALT_INST = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, RUN, HALT, STEP_WAIT} ifu_state_t;
  typedef logic [AW-1:0] iaddr_t;
  typedef logic [IW-1:0] inst_t;

  // Retirement counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/inst_mem.sv
// Instruction store: synchronous write, asynchronous read so the datapath
// sees the instruction at the PC in the same cycle.
module inst_mem
  import ifu_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem_array [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_array[waddr] <= wdata;
  end

  assign rdata = mem_array[raddr];

endmodule

// File: rtl/inst_fetch_unit.sv
// PC, instruction store and IDLE/RUN/HALT execution gate.
// Optional single-step mode is enabled with `define STEP_MODE_EN.
module inst_fetch_unit
  import ifu_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
`ifdef STEP_MODE_EN
  input  logic          step,
`endif
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic [AW-1:0] next_inst_addr,
  output logic [IW-1:0] curr_inst,
  output logic [AW-1:0] curr_inst_addr,
  output logic          exec_en,
  output logic          halted,
  output logic [15:0]   retired
);

  ifu_state_t    state_reg;
  logic [AW-1:0] pc_reg;
  logic [15:0]   retired_reg;
  logic          is_halt;
  logic          commit_slot;

`ifdef STEP_MODE_EN
  logic step_prev_reg;
  logic step_fire;
  assign step_fire = step & ~step_prev_reg;
`endif

  inst_mem u_inst_mem (
    .clk   (clk),
    .we    (load_valid & load_ready),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc_reg),
    .rdata (curr_inst)
  );

  assign is_halt = (curr_inst == HALT_INST);

  // A commit slot is a cycle in which the current instruction may retire;
  // the halt encoding turns it into a transition instead.
`ifdef STEP_MODE_EN
  assign commit_slot = (state_reg == RUN) || ((state_reg == STEP_WAIT) && step_fire);
`else
  assign commit_slot = (state_reg == RUN);
`endif

  assign exec_en        = commit_slot & ~is_halt;
  assign load_ready     = (state_reg == IDLE) || (state_reg == HALT);
  assign halted         = (state_reg == HALT);
  assign curr_inst_addr = pc_reg;
  assign retired        = retired_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      pc_reg      <= '0;
      retired_reg <= '0;
`ifdef STEP_MODE_EN
      step_prev_reg <= 1'b0;
`endif
    end else begin
`ifdef STEP_MODE_EN
      step_prev_reg <= step;
`endif
      unique case (state_reg)
        IDLE: begin
`ifdef STEP_MODE_EN
          if (start) state_reg <= STEP_WAIT;
`else
          if (start) state_reg <= RUN;
`endif
        end
        RUN, STEP_WAIT: begin
          if (commit_slot) begin
            if (is_halt) begin
              state_reg <= HALT;
            end else begin
              pc_reg      <= next_inst_addr;
              retired_reg <= sat_inc(retired_reg);
            end
          end
        end
        HALT: begin
          if (start) begin
            state_reg   <= IDLE;
            pc_reg      <= '0;
            retired_reg <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit against a cycle-level reference model.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        step_in;
  logic        load_valid;
  logic        load_ready;
  logic [4:0]  load_addr;
  logic [15:0] load_data;
  logic [4:0]  next_inst_addr;
  logic [15:0] curr_inst;
  logic [4:0]  curr_inst_addr;
  logic        exec_en;
  logic        halted;
  logic [15:0] retired;

  int errors = 0;
  int checks = 0;

`ifdef STEP_MODE_EN
  localparam bit STEP_BUILD = 1'b1;
`else
  localparam bit STEP_BUILD = 1'b0;
`endif

  // Reference model. m_mode: 0 idle, 1 run, 2 halt, 3 step-wait
  logic [15:0] m_mem [32];
  bit          m_known [32];
  int          m_pc;
  int          m_ret;
  int          m_mode;
  bit          m_step_prev;
  int          exec_seen;

  always #5 clk = ~clk;

  inst_fetch_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
`ifdef STEP_MODE_EN
    .step           (step_in),
`endif
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .next_inst_addr (next_inst_addr),
    .curr_inst      (curr_inst),
    .curr_inst_addr (curr_inst_addr),
    .exec_en        (exec_en),
    .halted         (halted),
    .retired        (retired)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ret = 0; m_mode = 0; m_step_prev = 1'b0;
  endtask

  function automatic bit model_slot();
    bit rise;
    rise = step_in && !m_step_prev;
    return (m_mode == 1) || (m_mode == 3 && rise);
  endfunction

  task automatic check_outputs(input string ctx);
    bit exp_exec;
    exp_exec = model_slot() && m_known[m_pc] && (m_mem[m_pc] != 16'hFFFF);
    if (m_known[m_pc]) check({ctx, ".inst"}, 32'(curr_inst), 32'(m_mem[m_pc]));
    check({ctx, ".addr"},    32'(curr_inst_addr), 32'(m_pc));
    check({ctx, ".exec"},    32'(exec_en), 32'(exp_exec));
    check({ctx, ".halted"},  32'(halted), 32'(m_mode == 2));
    check({ctx, ".ready"},   32'(load_ready), 32'(m_mode == 0 || m_mode == 2));
    check({ctx, ".retired"}, 32'(retired), 32'(m_ret));
    if (exec_en === 1'b1) exec_seen++;
    $display("%-8s pc=%0d inst=%h exec=%0b halted=%0b retired=%0d",
             ctx, curr_inst_addr, curr_inst, exec_en, halted, retired);
  endtask

  task automatic model_update();
    bit slot;
    bit is_halt;
    slot    = model_slot();
    is_halt = (m_mem[m_pc] == 16'hFFFF);
    if ((m_mode == 0 || m_mode == 2) && load_valid) begin
      m_mem[load_addr]   = load_data;
      m_known[load_addr] = 1'b1;
    end
    if (slot && !is_halt) begin
      m_pc = int'(next_inst_addr);
      if (m_ret < 65535) m_ret++;
    end else if (slot) begin
      m_mode = 2;
    end else if (start && m_mode == 0) begin
      m_mode = STEP_BUILD ? 3 : 1;
    end else if (start && m_mode == 2) begin
      m_mode = 0; m_pc = 0; m_ret = 0;
    end
    m_step_prev = step_in;
  endtask

  // Inputs are set just after a falling edge; one call covers one clock.
  task automatic cycle(input string ctx);
    #1;
    check_outputs(ctx);
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_word(input int addr, input logic [15:0] data);
    load_valid = 1'b1;
    load_addr  = 5'(addr);
    load_data  = data;
    cycle("load");
    load_valid = 1'b0;
  endtask

  task automatic async_reset(input bit check_now);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    if (check_now) begin
      check("rst.exec",    32'(exec_en), 32'd0);
      check("rst.addr",    32'(curr_inst_addr), 32'd0);
      check("rst.ready",   32'(load_ready), 32'd1);
      check("rst.halted",  32'(halted), 32'd0);
      check("rst.retired", 32'(retired), 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int  n;
    bit  branched;
    bit  wrapped;
    int  k;
    logic [15:0] w;

    for (int i = 0; i < 32; i++) begin m_known[i] = 1'b0; m_mem[i] = '0; end
    exec_seen = 0;
    reset_n = 1'b0; start = 1'b0; step_in = 1'b0; load_valid = 1'b0;
    load_addr = '0; load_data = '0; next_inst_addr = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cycle("reset");

    // Fill memory: test-plan words at 0..2, a non-halt program elsewhere.
    for (int a = 3; a < 31; a++) begin
      w = 16'($urandom_range(0, 16'hFFFE));
      load_word(a, w);
    end
    load_word(31, 16'h0000);
    load_word(0, 16'h1234);
    load_word(1, 16'h0001);
    load_word(2, 16'hFFFF);

    // Straight-line run to halt while a blocked load is offered.
    start = 1'b1;
    cycle("start");
    start = 1'b0;
    n = 0;
    while (m_mode != 2 && n < 10) begin
      next_inst_addr = 5'(m_pc + 1);
      load_valid = 1'b1; load_addr = 5'd3; load_data = 16'hAAAA;
      cycle("run1");
      n++;
    end
    load_valid = 1'b0;
    #1;
    check("tp.halted",  32'(halted), 32'd1);
    check("tp.retired", 32'(retired), 32'd2);
    check("tp.addr",    32'(curr_inst_addr), 32'd2);

    // Back to IDLE, replace the halt, run through a branch and a wrap.
    start = 1'b1;
    cycle("halt2idle");
    start = 1'b0;
    load_word(2, 16'h0002);
    start = 1'b1;
    cycle("start");
    start = 1'b0;
    branched = 1'b0; wrapped = 1'b0; n = 0;
    while (!(wrapped && m_pc == 7) && n < 60) begin
      if (m_pc == 1 && !branched) begin
        next_inst_addr = 5'd20;
        branched = 1'b1;
        cycle("branch");
        check("branch.addr", 32'(curr_inst_addr), 32'd20);
      end else if (m_pc == 31) begin
        next_inst_addr = 5'd0;
        wrapped = 1'b1;
        k = m_ret;
        cycle("wrap");
        check("wrap.addr", 32'(curr_inst_addr), 32'd0);
        check("wrap.retired", 32'(retired), 32'(k + 1));
      end else begin
        next_inst_addr = 5'(m_pc + 1);
        cycle("run2");
      end
      n++;
    end
    check("run2.reached_pc7", 32'(curr_inst_addr), 32'd7);
    async_reset(1'b1);
    cycle("idle");

    // Randomised programs with one halt word, random branches, loads and starts.
    k = $urandom_range(0, 31);
    load_word(k, 16'hFFFF);
    start = 1'b1;
    cycle("start");
    start = 1'b0;
    for (int c = 0; c < 150; c++) begin
      next_inst_addr = ($urandom_range(0, 1) == 0) ? 5'(m_pc + 1) : 5'($urandom_range(0, 31));
      start      = ($urandom_range(0, 5) == 0);
      load_valid = ($urandom_range(0, 3) == 0);
      load_addr  = 5'($urandom_range(0, 31));
      load_data  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      cycle("rand");
    end
    start = 1'b0; load_valid = 1'b0;

`ifdef STEP_MODE_EN
    async_reset(1'b0);
    for (int a = 0; a < 8; a++) load_word(a, 16'(16'h0100 + a));
    start = 1'b1;
    cycle("start");
    start = 1'b0;
    exec_seen = 0;
    begin
      logic [15:0] pattern;
      pattern = 16'b0011_1100_1000_0100;
      for (int c = 0; c < 16; c++) begin
        step_in = pattern[c];
        next_inst_addr = 5'(m_pc + 1);
        cycle("step");
        if (c == 9) check("step.two_pulses", 32'(retired), 32'd2);
      end
    end
    step_in = 1'b0;
    check("step.exec_cycles", 32'(exec_seen), 32'd3);
    check("step.retired", 32'(retired), 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
